// File: rtl/tpu_sequencer_if.sv
// Host, operand-memory, systolic-array and result-mux signals
// that the TPU job sequencer drives or observes.
interface tpu_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic       cfg_transpose;
  logic       cfg_activation;
  logic       abort;
  logic       mem_we;
  logic [2:0] mem_addr;
  logic       pe_clear;
  logic       mmu_en;
  logic [2:0] mmu_cycle;
  logic       transpose_q;
  logic       activation_q;
  logic [1:0] res_sel;
  logic       res_half;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  modport master (
    input  in_valid, cfg_transpose, cfg_activation,
    input  abort, out_ready,
    output in_ready, mem_we, mem_addr, pe_clear,
    output mmu_en, mmu_cycle, transpose_q, activation_q,
    output res_sel, res_half, out_valid, busy, done
  );

  modport slave (
    output in_valid, cfg_transpose, cfg_activation,
    output abort, out_ready,
    input  in_ready, mem_we, mem_addr, pe_clear,
    input  mmu_en, mmu_cycle, transpose_q, activation_q,
    input  res_sel, res_half, out_valid, busy, done
  );
endinterface

// File: rtl/tpu_sequencer.sv
// Job controller for the 2x2 systolic TPU: load 8 operand bytes,
// clear PEs, run the compute window, drain 8 result bytes.
module tpu_sequencer #(
  parameter int COMPUTE_CYCLES = 5
) (
  input logic             clk,
  input logic             rst_n,
  tpu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [2:0] LAST_CYC = 3'(COMPUTE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] load_q, load_d;
  logic [2:0] cyc_q, cyc_d;
  logic [2:0] beat_q, beat_d;
  logic       xpose_q, xpose_d;
  logic       act_q, act_d;
  logic       abort_q, abort_d;
  logic       in_ready;
  logic       accept;

  assign in_ready = (state_q == S_IDLE) | (state_q == S_LOAD);
  // abort suppresses the write even when a byte is offered
  assign accept = bus.in_valid & in_ready & ~bus.abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      load_q  <= '0;
      cyc_q   <= '0;
      beat_q  <= '0;
      xpose_q <= 1'b0;
      act_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      cyc_q   <= cyc_d;
      beat_q  <= beat_d;
      xpose_q <= xpose_d;
      act_q   <= act_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    cyc_d   = cyc_q;
    beat_d  = beat_q;
    xpose_d = xpose_q;
    act_d   = act_q;
    abort_d = 1'b0;
    if (bus.abort) begin
      state_d = S_IDLE;
      load_d  = '0;
      cyc_d   = '0;
      beat_d  = '0;
      abort_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            xpose_d = bus.cfg_transpose;
            act_d   = bus.cfg_activation;
            load_d  = 3'd1;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept) begin
            load_d = load_q + 3'd1;
            if (load_q == 3'd7) begin
              load_d  = '0;
              state_d = S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          cyc_d   = '0;
          state_d = S_COMPUTE;
        end
        S_COMPUTE: begin
          cyc_d = cyc_q + 3'd1;
          if (cyc_q == LAST_CYC) begin
            cyc_d   = '0;
            beat_d  = '0;
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (bus.out_ready) begin
            beat_d = beat_q + 3'd1;
            if (beat_q == 3'd7) begin
              beat_d  = '0;
              state_d = S_DONE;
            end
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready     = in_ready;
    bus.mem_we       = accept;
    bus.mem_addr     = '0;
    bus.pe_clear     = abort_q;
    bus.mmu_en       = 1'b0;
    bus.mmu_cycle    = '0;
    bus.res_sel      = '0;
    bus.res_half     = 1'b0;
    bus.out_valid    = 1'b0;
    bus.done         = 1'b0;
    bus.busy         = (state_q != S_IDLE);
    bus.transpose_q  = xpose_q;
    bus.activation_q = act_q;
    unique case (1'b1)
      (state_q == S_LOAD):    bus.mem_addr = load_q;
      (state_q == S_CLEAR):   bus.pe_clear = 1'b1;
      (state_q == S_COMPUTE): begin
        bus.mmu_en    = 1'b1;
        bus.mmu_cycle = cyc_q;
      end
      (state_q == S_DRAIN): begin
        bus.out_valid = 1'b1;
        bus.res_sel   = beat_q[2:1];
        bus.res_half  = beat_q[0];
      end
      (state_q == S_DONE):    bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tpu_sequencer.sv
// Directed cycle-by-cycle vectors for tpu_sequencer plus
// hand-written async-reset-in-drain sequence.
module tb_tpu_sequencer;

  typedef struct packed {
    logic       ir;
    logic       we;
    logic [2:0] addr;
    logic       pc;
    logic       me;
    logic [2:0] mc;
    logic       tq;
    logic       aq;
    logic [1:0] rs;
    logic       rh;
    logic       ov;
    logic       bz;
    logic       dn;
  } exp_t;

  typedef struct {
    logic  iv;
    logic  ct;
    logic  ca;
    logic  ab;
    logic  ordy;
    exp_t  e;
    string tag;
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  vec_t vq[$];

  tpu_sequencer_if bus ();

  tpu_sequencer #(.COMPUTE_CYCLES(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t E(
    logic ir, logic we, logic [2:0] addr, logic pc,
    logic me, logic [2:0] mc, logic tq, logic aq,
    logic [1:0] rs, logic rh, logic ov, logic bz, logic dn);
    exp_t x;
    x.ir = ir; x.we = we; x.addr = addr; x.pc = pc;
    x.me = me; x.mc = mc; x.tq = tq; x.aq = aq;
    x.rs = rs; x.rh = rh; x.ov = ov; x.bz = bz; x.dn = dn;
    return x;
  endfunction

  function automatic exp_t cur();
    return E(bus.in_ready, bus.mem_we, bus.mem_addr,
             bus.pe_clear, bus.mmu_en, bus.mmu_cycle,
             bus.transpose_q, bus.activation_q, bus.res_sel,
             bus.res_half, bus.out_valid, bus.busy, bus.done);
  endfunction

  task automatic push(logic iv, logic ct, logic ca, logic ab,
                      logic ordy, exp_t e, string tag);
    vec_t v;
    v.iv = iv; v.ct = ct; v.ca = ca; v.ab = ab;
    v.ordy = ordy; v.e = e; v.tag = tag;
    vq.push_back(v);
  endtask

  task automatic check(exp_t got, exp_t want, string tag);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // load (no gaps), clear, compute, drain at full rate, done
  task automatic add_plain_job(logic ct, logic ca,
                               logic ptq, logic paq);
    push(1, ct, ca, 0, 1,
         E(1,1,0,0,0,0,ptq,paq,0,0,0,0,0), "idle_accept");
    for (int i = 1; i < 8; i++)
      push(1, 0, 0, 0, 1,
           E(1,1,3'(i),0,0,0,ct,ca,0,0,0,1,0), "load");
    push(1, 0, 0, 0, 1,
         E(0,0,0,1,0,0,ct,ca,0,0,0,1,0), "clear");
    for (int c = 0; c < 5; c++)
      push(0, 0, 0, 0, 1,
           E(0,0,0,0,1,3'(c),ct,ca,0,0,0,1,0), "compute");
    for (int b = 0; b < 8; b++)
      push(0, 0, 0, 0, 1,
           E(0,0,0,0,0,0,ct,ca,2'(b >> 1),1'(b & 1),1,1,0),
           "drain");
    push(0, 0, 0, 0, 1,
         E(0,0,0,0,0,0,ct,ca,0,0,0,1,1), "done");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.in_valid = 0;
    bus.cfg_transpose = 0;
    bus.cfg_activation = 0;
    bus.abort = 0;
    bus.out_ready = 0;

    // job 1: basic, transpose requested only on the first byte
    add_plain_job(1, 0, 0, 0);

    // job 2: back-to-back, stalled load, backpressure at beat 2
    push(1, 0, 1, 0, 1,
         E(1,1,0,0,0,0,1,0,0,0,0,0,0), "j2_accept");
    for (int i = 1; i < 8; i++) begin
      push(0, 0, 0, 0, 1,
           E(1,0,3'(i),0,0,0,0,1,0,0,0,1,0), "j2_gap");
      push(0, 0, 0, 0, 1,
           E(1,0,3'(i),0,0,0,0,1,0,0,0,1,0), "j2_gap");
      push(1, 0, 0, 0, 1,
           E(1,1,3'(i),0,0,0,0,1,0,0,0,1,0), "j2_load");
    end
    push(0, 0, 0, 0, 1,
         E(0,0,0,1,0,0,0,1,0,0,0,1,0), "j2_clear");
    for (int c = 0; c < 5; c++)
      push(0, 0, 0, 0, 1,
           E(0,0,0,0,1,3'(c),0,1,0,0,0,1,0), "j2_compute");
    push(0, 0, 0, 0, 1,
         E(0,0,0,0,0,0,0,1,0,0,1,1,0), "j2_beat0");
    push(0, 0, 0, 0, 1,
         E(0,0,0,0,0,0,0,1,0,1,1,1,0), "j2_beat1");
    for (int k = 0; k < 3; k++)
      push(0, 0, 0, 0, 0,
           E(0,0,0,0,0,0,0,1,1,0,1,1,0), "j2_hold");
    for (int b = 2; b < 8; b++)
      push(0, 0, 0, 0, 1,
           E(0,0,0,0,0,0,0,1,2'(b >> 1),1'(b & 1),1,1,0),
           "j2_drain");
    push(0, 0, 0, 0, 1,
         E(0,0,0,0,0,0,0,1,0,0,0,1,1), "j2_done");
    push(0, 0, 0, 0, 1,
         E(1,0,0,0,0,0,0,1,0,0,0,0,0), "j2_idle");

    // job 3: abort in compute cycle 2
    push(1, 0, 0, 0, 1,
         E(1,1,0,0,0,0,0,1,0,0,0,0,0), "j3_accept");
    for (int i = 1; i < 8; i++)
      push(1, 0, 0, 0, 1,
           E(1,1,3'(i),0,0,0,0,0,0,0,0,1,0), "j3_load");
    push(0, 0, 0, 0, 1,
         E(0,0,0,1,0,0,0,0,0,0,0,1,0), "j3_clear");
    push(0, 0, 0, 0, 1,
         E(0,0,0,0,1,0,0,0,0,0,0,1,0), "j3_cyc0");
    push(0, 0, 0, 0, 1,
         E(0,0,0,0,1,1,0,0,0,0,0,1,0), "j3_cyc1");
    push(0, 0, 0, 1, 1,
         E(0,0,0,0,1,2,0,0,0,0,0,1,0), "j3_abort");
    push(0, 0, 0, 0, 1,
         E(1,0,0,1,0,0,0,0,0,0,0,0,0), "abort_idle");
    // abort with a byte offered in IDLE: no write, no latch
    push(1, 1, 1, 1, 1,
         E(1,0,0,0,0,0,0,0,0,0,0,0,0), "abort_iv");
    push(0, 0, 0, 0, 1,
         E(1,0,0,1,0,0,0,0,0,0,0,0,0), "abort_iv_after");

    // job 4: full job after aborts
    add_plain_job(0, 0, 0, 0);
    push(0, 0, 0, 0, 1,
         E(1,0,0,0,0,0,0,0,0,0,0,0,0), "j4_idle");

    #1;
    check(cur(), E(1,0,0,0,0,0,0,0,0,0,0,0,0), "reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      bus.in_valid       = vq[i].iv;
      bus.cfg_transpose  = vq[i].ct;
      bus.cfg_activation = vq[i].ca;
      bus.abort          = vq[i].ab;
      bus.out_ready      = vq[i].ordy;
      #1;
      check(cur(), vq[i].e, vq[i].tag);
    end

    // async reset while draining
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.in_valid = 1;
      bus.abort    = 0;
      bus.out_ready = 0;
    end
    @(negedge clk);
    bus.in_valid = 0;
    begin
      int n;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 30) begin
        @(negedge clk);
        n++;
      end
      tests++;
      if (bus.out_valid !== 1'b1) begin
        fails++;
        $display("FAIL drain_wait: out_valid %b want 1",
                 bus.out_valid);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    check(cur(), E(1,0,0,0,0,0,0,0,0,0,0,0,0), "async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tpu_sequencer.md
# tpu_sequencer

Job-level controller for the 2x2 systolic TPU datapath. It accepts a stream of 8 operand bytes from the host (4 weights, then 4 inputs) and drives the operand memory write port. It then clears the PEs, runs the compute window on the systolic array, and streams the four 16-bit results back as 8 bytes under a valid/ready handshake. It sits between the host pins and the memory / systolic-array / output-mux datapath, and owns all sequencing of that datapath.

## Interface
Parameters:
- COMPUTE_CYCLES, 5, number of cycles mmu_en is held high. Legal range 1..8; mmu_cycle is 3 bits.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  host presents an operand byte this cycle
- in_ready  out  1  sequencer can accept an operand byte (combinational from state)
- cfg_transpose  in  1  transpose request, sampled on first accepted byte of a job
- cfg_activation  in  1  ReLU request, sampled on first accepted byte of a job
- abort  in  1  synchronous job cancel
- mem_we  out  1  operand memory write strobe, equal to in_valid & in_ready
- mem_addr  out  3  operand memory address (0-3 weights, 4-7 inputs)
- pe_clear  out  1  clear PE accumulators
- mmu_en  out  1  systolic array / feeder enable
- mmu_cycle  out  3  compute cycle index
- transpose_q  out  1  latched cfg_transpose for the current job
- activation_q  out  1  latched cfg_activation for the current job
- res_sel  out  2  result select: 0=c00, 1=c01, 2=c10, 3=c11
- res_half  out  1  0 = low byte, 1 = high byte of the selected result
- out_valid  out  1  result byte available on the output mux
- out_ready  in  1  host consumes the result byte
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a job completes

## Operation
- The FSM has six states: IDLE, LOAD, CLEAR, COMPUTE, DRAIN, DONE.
- **IDLE:** in_ready=1, mem_addr=0.
  - An accept (in_valid & in_ready) writes addr 0, latches transpose_q and activation_q, sets load_cnt=1, and moves to LOAD.
- **LOAD:** in_ready=1, mem_addr=load_cnt.
  - Each accept writes and increments load_cnt.
  - The accept at addr 7 moves to CLEAR.
  - Gaps (in_valid low) are legal and stall indefinitely.
- **CLEAR:** in_ready=0, pe_clear=1 for exactly one cycle, then COMPUTE with cyc=0.
- **COMPUTE:** mmu_en=1, mmu_cycle=cyc.
  - cyc increments each cycle.
  - On cyc==COMPUTE_CYCLES-1, go to DRAIN with beat=0.
- **DRAIN:** out_valid=1, res_sel=beat[2:1], res_half=beat[0].
  - beat advances only on out_valid & out_ready.
  - Byte order: c00.lo, c00.hi, c01.lo, c01.hi, c10.lo, c10.hi, c11.lo, c11.hi.
  - The handshake at beat 7 moves to DONE.
  - out_valid stays high and res_sel/res_half stay stable while out_ready is low.
- **DONE:** done=1 for one cycle, then IDLE. transpose_q and activation_q hold until the next job's first accept.
- **abort:** in any state, abort returns the FSM to IDLE on the next edge and asserts pe_clear for that one cycle.
  - All counters zero.
  - done is not pulsed.
  - abort wins over a simultaneous in_valid: mem_we=0 and no latch.
- in_ready=0 in CLEAR, COMPUTE, DRAIN and DONE. Host bytes presented then are ignored, not buffered.
- Outside their states, mem_we, pe_clear, mmu_en, out_valid and done are 0. mmu_cycle, res_sel and res_half read 0.

## Timing
- **Reset values:**
  - state=IDLE.
  - in_ready=1.
  - All other outputs 0: mem_we, mem_addr, pe_clear, mmu_en, mmu_cycle, transpose_q, activation_q, res_sel, res_half, out_valid, busy, done.
- State, counters and latched config are registers. All outputs are decoded from registered state, except mem_we, which is also gated by in_valid.
- **Latency:** with the 8th byte accepted at edge T:
  - pe_clear is high in cycle T+1.
  - mmu_en is high in cycles T+2 .. T+1+COMPUTE_CYCLES.
  - out_valid first rises in cycle T+2+COMPUTE_CYCLES.
- With out_ready tied high, DRAIN lasts 8 cycles, and done pulses the cycle after the last beat.
- **Back-to-back jobs:** IDLE is re-entered the cycle after DONE. A new byte may be accepted in that first IDLE cycle.
- Asynchronous reset mid-job forces the reset values immediately, with no done pulse. Operand memory contents are not the sequencer's concern.

## Test plan
- **Basic job:** reset; 8 bytes on consecutive cycles (W=1,2,3,4; X=5,6,7,8), out_ready=1.
  - mem_addr 0..7 with mem_we each cycle.
  - pe_clear one cycle, then mmu_en for 5 cycles with mmu_cycle 0..4.
  - 8 beats with {res_sel,res_half} = 0,1,2,...,7.
  - done single pulse; busy low after.
- **Load stalls:** in_valid toggled 1,0,0,1,... → mem_addr advances only on accepted bytes; CLEAR only after the 8th accept.
- **Output backpressure:** out_ready low 3 cycles at beat 2 → res_sel=1 and res_half=0 held with out_valid=1; no skipped or duplicated beat.
- **Config latch:** cfg_transpose=1 on the first byte, dropped to 0 afterward → transpose_q=1 through DONE and the subsequent IDLE.
- **Abort:** abort during COMPUTE cycle 2 → next cycle IDLE with pe_clear=1, mmu_en=0, no done. A following full job completes normally. Separately, abort together with in_valid in IDLE → mem_we=0.
- **Async reset in DRAIN:** rst_n low → out_valid=0, busy=0 and in_ready=1 without waiting for a clock edge.
